// File: rtl/instruction_decode.sv
// instruction_decode
// Second pipeline stage. Decodes an ARM-subset instruction (data-processing,
// load/store, branch), reads operands through the register-file read ports and
// detects load-use hazards against the execute stage. The result is presented
// to execute as a registered decode bundle.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   valid_i, pc_i, instr_i        fetched instruction
//   stall_i, flush_i              execute back-pressure / branch-taken discard
//   ex_valid_i, ex_load_i, ex_rd_i   instruction currently in execute
//   rn_addr_o, rm_addr_o          register-file read addresses (combinational)
//   rn_data_i, rm_data_i          register-file read data (combinational)
//   stall_o                       upstream hold request (combinational)
//   valid_o .. undef_o            registered decode bundle
//
// Fields that have no meaning for the decoded class are driven to zero.
// rn_data_o always carries the Rn operand value, whatever the class.
module instruction_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        ex_valid_i,
    input  logic        ex_load_i,
    input  logic [3:0]  ex_rd_i,
    output logic [3:0]  rn_addr_o,
    output logic [3:0]  rm_addr_o,
    input  logic [31:0] rn_data_i,
    input  logic [31:0] rm_data_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [3:0]  cond_o,
    output logic [1:0]  class_o,
    output logic [3:0]  alu_op_o,
    output logic        set_flags_o,
    output logic [3:0]  rd_o,
    output logic [31:0] rn_data_o,
    output logic [31:0] op2_o,
    output logic        op2_imm_o,
    output logic [1:0]  shift_type_o,
    output logic [4:0]  shift_amt_o,
    output logic        mem_pre_o,
    output logic        mem_up_o,
    output logic        mem_byte_o,
    output logic        mem_wb_o,
    output logic        mem_load_o,
    output logic        link_o,
    output logic [31:0] branch_target_o,
    output logic        undef_o
);

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_DP   = 2'b01;
    localparam logic [1:0] CLS_LS   = 2'b10;
    localparam logic [1:0] CLS_BR   = 2'b11;

    logic [31:0] pc_plus8;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [31:0] imm32;
    logic [63:0] rot_dbl;
    logic        reg_shift;
    logic        uses_rn;
    logic        uses_rm;
    logic        hazard;

    logic [1:0]  d_class;
    logic [3:0]  d_alu_op;
    logic        d_set_flags;
    logic [3:0]  d_rd;
    logic [31:0] d_op2;
    logic        d_op2_imm;
    logic [1:0]  d_shift_type;
    logic [4:0]  d_shift_amt;
    logic        d_link;
    logic [31:0] d_target;
    logic        d_undef;

    assign rn_addr_o = instr_i[19:16];
    assign rm_addr_o = instr_i[3:0];

    // R15 reads return the architectural PC, which runs two words ahead.
    assign pc_plus8 = pc_i + 32'd8;
    assign rn_val   = (instr_i[19:16] == 4'hF) ? pc_plus8 : rn_data_i;
    assign rm_val   = (instr_i[3:0]   == 4'hF) ? pc_plus8 : rm_data_i;

    // Rotating the doubled value right gives a 32-bit rotate for free.
    assign imm32   = {24'd0, instr_i[7:0]};
    assign rot_dbl = {imm32, imm32} >> {instr_i[11:8], 1'b0};

    // Register-specified shifts are not supported in this subset.
    assign reg_shift = ~instr_i[25] & instr_i[4];

    always_comb begin
        d_class      = CLS_NONE;
        d_alu_op     = 4'd0;
        d_set_flags  = 1'b0;
        d_rd         = 4'd0;
        d_op2        = 32'd0;
        d_op2_imm    = 1'b0;
        d_shift_type = 2'd0;
        d_shift_amt  = 5'd0;
        d_link       = 1'b0;
        d_target     = 32'd0;
        d_undef      = 1'b0;
        if (instr_i[27:26] == 2'b00 && !reg_shift) begin
            d_class     = CLS_DP;
            d_alu_op    = instr_i[24:21];
            d_set_flags = instr_i[20];
            d_rd        = instr_i[15:12];
            if (instr_i[25]) begin
                d_op2     = rot_dbl[31:0];
                d_op2_imm = 1'b1;
            end else begin
                d_op2        = rm_val;
                d_shift_type = instr_i[6:5];
                d_shift_amt  = instr_i[11:7];
            end
        end else if (instr_i[27:26] == 2'b01 && !reg_shift) begin
            d_class = CLS_LS;
            d_rd    = instr_i[15:12];
            if (!instr_i[25]) begin
                d_op2     = {20'd0, instr_i[11:0]};
                d_op2_imm = 1'b1;
            end else begin
                d_op2        = rm_val;
                d_shift_type = instr_i[6:5];
                d_shift_amt  = instr_i[11:7];
            end
        end else if (instr_i[27:25] == 3'b101) begin
            d_class  = CLS_BR;
            d_link   = instr_i[24];
            d_rd     = instr_i[24] ? 4'd14 : 4'd0;
            d_target = pc_plus8 + {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
        end else begin
            d_undef = 1'b1;
        end
    end

    // MOV/MVN ignore Rn; immediate forms ignore Rm; branches read nothing.
    assign uses_rn = ((d_class == CLS_DP) && (instr_i[24:21] != 4'b1101)
                      && (instr_i[24:21] != 4'b1111)) || (d_class == CLS_LS);
    assign uses_rm = ((d_class == CLS_DP) || (d_class == CLS_LS)) && !d_op2_imm;

    assign hazard = valid_i & ex_valid_i & ex_load_i &
                    ((uses_rn & (ex_rd_i == rn_addr_o)) |
                     (uses_rm & (ex_rd_i == rm_addr_o)));

    assign stall_o = stall_i | hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o         <= 1'b0;
            pc_o            <= 32'd0;
            cond_o          <= 4'd0;
            class_o         <= CLS_NONE;
            alu_op_o        <= 4'd0;
            set_flags_o     <= 1'b0;
            rd_o            <= 4'd0;
            rn_data_o       <= 32'd0;
            op2_o           <= 32'd0;
            op2_imm_o       <= 1'b0;
            shift_type_o    <= 2'd0;
            shift_amt_o     <= 5'd0;
            mem_pre_o       <= 1'b0;
            mem_up_o        <= 1'b0;
            mem_byte_o      <= 1'b0;
            mem_wb_o        <= 1'b0;
            mem_load_o      <= 1'b0;
            link_o          <= 1'b0;
            branch_target_o <= 32'd0;
            undef_o         <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            undef_o <= 1'b0;
        end else if (stall_i) begin
            // hold
        end else if (hazard) begin
            valid_o <= 1'b0;
            class_o <= CLS_NONE;
            undef_o <= 1'b0;
        end else begin
            valid_o         <= valid_i;
            pc_o            <= pc_i;
            cond_o          <= instr_i[31:28];
            class_o         <= d_class;
            alu_op_o        <= d_alu_op;
            set_flags_o     <= d_set_flags;
            rd_o            <= d_rd;
            rn_data_o       <= rn_val;
            op2_o           <= d_op2;
            op2_imm_o       <= d_op2_imm;
            shift_type_o    <= d_shift_type;
            shift_amt_o     <= d_shift_amt;
            mem_pre_o       <= (d_class == CLS_LS) & instr_i[24];
            mem_up_o        <= (d_class == CLS_LS) & instr_i[23];
            mem_byte_o      <= (d_class == CLS_LS) & instr_i[22];
            mem_wb_o        <= (d_class == CLS_LS) & instr_i[21];
            mem_load_o      <= (d_class == CLS_LS) & instr_i[20];
            link_o          <= d_link;
            branch_target_o <= d_target;
            undef_o         <= d_undef & valid_i;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst, valid_i, stall_i, flush_i, ex_valid_i, ex_load_i;
    logic [31:0] pc_i, instr_i, rn_data_i, rm_data_i;
    logic [3:0]  ex_rd_i, rn_addr_o, rm_addr_o;
    logic        stall_o, valid_o, set_flags_o, op2_imm_o;
    logic [31:0] pc_o, rn_data_o, op2_o, branch_target_o;
    logic [3:0]  cond_o, alu_op_o, rd_o;
    logic [1:0]  class_o, shift_type_o;
    logic [4:0]  shift_amt_o;
    logic        mem_pre_o, mem_up_o, mem_byte_o, mem_wb_o, mem_load_o, link_o, undef_o;

    logic [31:0] rf [16];
    assign rn_data_i = rf[instr_i[19:16]];
    assign rm_data_i = rf[instr_i[3:0]];

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
        .stall_i(stall_i), .flush_i(flush_i), .ex_valid_i(ex_valid_i),
        .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .rn_addr_o(rn_addr_o),
        .rm_addr_o(rm_addr_o), .rn_data_i(rn_data_i), .rm_data_i(rm_data_i),
        .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o), .cond_o(cond_o),
        .class_o(class_o), .alu_op_o(alu_op_o), .set_flags_o(set_flags_o),
        .rd_o(rd_o), .rn_data_o(rn_data_o), .op2_o(op2_o), .op2_imm_o(op2_imm_o),
        .shift_type_o(shift_type_o), .shift_amt_o(shift_amt_o),
        .mem_pre_o(mem_pre_o), .mem_up_o(mem_up_o), .mem_byte_o(mem_byte_o),
        .mem_wb_o(mem_wb_o), .mem_load_o(mem_load_o), .link_o(link_o),
        .branch_target_o(branch_target_o), .undef_o(undef_o)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  cond;
        logic [1:0]  cls;
        logic [3:0]  alu_op;
        logic        set_flags;
        logic [3:0]  rd;
        logic [31:0] rn_data;
        logic [31:0] op2;
        logic        op2_imm;
        logic [1:0]  shift_type;
        logic [4:0]  shift_amt;
        logic [4:0]  mem;      // P U B W L
        logic        link;
        logic [31:0] target;
        logic        undef;
    } bundle_t;

    typedef enum int {M_RST, M_FLUSH, M_BUBBLE, M_CAPTURE} mode_t;

    int      n_tests = 0;
    int      n_fail  = 0;
    bundle_t exp_b;
    mode_t   mode;
    bit      chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [3:0] r, input logic [31:0] pc);
        return (r == 4'd15) ? pc + 32'd8 : rf[r];
    endfunction

    // Reference decode straight from the instruction-set rules.
    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        bundle_t     b;
        logic [31:0] v;
        logic signed [31:0] off;
        b = '0;
        b.pc      = pc;
        b.cond    = ins[31:28];
        b.rn_data = operand(ins[19:16], pc);
        if ((ins[27:26] == 2'b00 || ins[27:26] == 2'b01) && !(ins[25] == 1'b0 && ins[4] == 1'b1)) begin
            b.rd = ins[15:12];
            if (ins[27:26] == 2'b00) begin
                b.cls       = 2'd1;
                b.alu_op    = ins[24:21];
                b.set_flags = ins[20];
            end else begin
                b.cls = 2'd2;
                b.mem = ins[24:20];
            end
            if ((b.cls == 2'd1) == (ins[25] == 1'b1)) begin
                if (b.cls == 2'd1) begin
                    v = {24'd0, ins[7:0]};
                    for (int k = 0; k < int'(ins[11:8]) * 2; k++) v = {v[0], v[31:1]};
                end else begin
                    v = {20'd0, ins[11:0]};
                end
                b.op2     = v;
                b.op2_imm = 1'b1;
            end else begin
                b.op2        = operand(ins[3:0], pc);
                b.shift_type = ins[6:5];
                b.shift_amt  = ins[11:7];
            end
        end else if (ins[27:25] == 3'b101) begin
            b.cls    = 2'd3;
            b.link   = ins[24];
            b.rd     = ins[24] ? 4'd14 : 4'd0;
            off      = {{8{ins[23]}}, ins[23:0]};
            b.target = pc + 32'd8 + off * 4;
        end else begin
            b.undef = 1'b1;
        end
        return b;
    endfunction

    function automatic bit model_hazard();
        bundle_t b;
        bit      rn_used, rm_used;
        b = model_decode(instr_i, pc_i);
        rn_used = (b.cls == 2'd1 && b.alu_op != 4'd13 && b.alu_op != 4'd15) || b.cls == 2'd2;
        rm_used = (b.cls == 2'd1 || b.cls == 2'd2) && !b.op2_imm;
        return valid_i && ex_valid_i && ex_load_i &&
               ((rn_used && ex_rd_i == instr_i[19:16]) || (rm_used && ex_rd_i == instr_i[3:0]));
    endfunction

    // Model of the registered bundle, advanced on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_b  = '0;
            mode   = M_RST;
            chk_en = 1;
        end else if (chk_en) begin
            if (flush_i) begin
                exp_b.valid = 1'b0;
                mode = M_FLUSH;
            end else if (stall_i) begin
            end else if (model_hazard()) begin
                exp_b.valid = 1'b0;
                exp_b.cls   = 2'd0;
                exp_b.undef = 1'b0;
                mode = M_BUBBLE;
            end else begin
                exp_b       = model_decode(instr_i, pc_i);
                exp_b.valid = valid_i;
                exp_b.undef = exp_b.undef & valid_i;
                mode = M_CAPTURE;
            end
        end
    end

    // Compare process: checks every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall_o", stall_o, stall_i | model_hazard());
            check("rn_addr_o", rn_addr_o, instr_i[19:16]);
            check("rm_addr_o", rm_addr_o, instr_i[3:0]);
            check("valid_o", valid_o, exp_b.valid);
            if (mode != M_FLUSH) check("undef_o", undef_o, exp_b.undef);
            if (mode == M_BUBBLE) check("class_o", class_o, exp_b.cls);
            if (mode == M_RST || (mode == M_CAPTURE && exp_b.valid)) begin
                check("pc_o", pc_o, exp_b.pc);
                check("cond_o", cond_o, exp_b.cond);
                check("class_o", class_o, exp_b.cls);
                check("alu_op_o", alu_op_o, exp_b.alu_op);
                check("set_flags_o", set_flags_o, exp_b.set_flags);
                check("rd_o", rd_o, exp_b.rd);
                check("rn_data_o", rn_data_o, exp_b.rn_data);
                check("op2_o", op2_o, exp_b.op2);
                check("op2_imm_o", op2_imm_o, exp_b.op2_imm);
                check("shift_type_o", shift_type_o, exp_b.shift_type);
                check("shift_amt_o", shift_amt_o, exp_b.shift_amt);
                check("mem_flags", {mem_pre_o, mem_up_o, mem_byte_o, mem_wb_o, mem_load_o}, exp_b.mem);
                check("link_o", link_o, exp_b.link);
                check("branch_target_o", branch_target_o, exp_b.target);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        w[19:16] = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        w[3:0]   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0, 1, 2, 3: w[27:26] = 2'b00;
            4, 5, 6:    w[27:26] = 2'b01;
            7, 8:       w[27:25] = 3'b101;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        rf[15] = 32'hDEADBEEF;
        rst = 1; valid_i = 1; pc_i = $urandom; instr_i = $urandom;
        stall_i = 0; flush_i = 0; ex_valid_i = 0; ex_load_i = 0; ex_rd_i = 0;
        tick();
        pc_i = $urandom; instr_i = $urandom;
        tick();
        @(negedge clk);
        check("rst valid_o", valid_o, 0);
        check("rst pc_o", pc_o, 0);
        check("rst op2_o", op2_o, 0);
        check("rst branch_target_o", branch_target_o, 0);
        check("rst stall_o", stall_o, 0);

        // immediate rotate: ADD r1, r2, #0xFF ror 8
        tick();
        rst = 0; valid_i = 1; pc_i = 32'h1000; instr_i = 32'hE28214FF;
        @(negedge clk);
        check("imm rn_addr_o", rn_addr_o, 2);
        tick();
        pc_i = 32'h100; instr_i = 32'hEAFFFFFE;
        @(negedge clk);
        check("imm class_o", class_o, 2'b01);
        check("imm alu_op_o", alu_op_o, 4'b0100);
        check("imm rd_o", rd_o, 1);
        check("imm op2_o", op2_o, 32'hFF000000);
        check("imm op2_imm_o", op2_imm_o, 1);

        // branches, including address wrap
        tick();
        pc_i = 32'hFFFFFFF0; instr_i = 32'hEA000001;
        @(negedge clk);
        check("br self target", branch_target_o, 32'h100);
        check("br self link_o", link_o, 0);
        tick();
        pc_i = 32'hFFFFFFF8; instr_i = 32'hEB000001;
        @(negedge clk);
        check("br high target", branch_target_o, 32'hFFFFFFFC);
        tick();
        @(negedge clk);
        check("bl wrap target", branch_target_o, 32'h00000004);
        check("bl link_o", link_o, 1);
        check("bl rd_o", rd_o, 14);

        // load-use: ADD r4, r3, r5 behind a load to r3
        tick();
        pc_i = 32'h300; instr_i = 32'hE0834005;
        ex_valid_i = 1; ex_load_i = 1; ex_rd_i = 3;
        @(negedge clk);
        check("lu stall_o", stall_o, 1);
        tick();
        ex_load_i = 0;
        @(negedge clk);
        check("lu bubble valid_o", valid_o, 0);
        check("lu released stall_o", stall_o, 0);
        tick();
        ex_load_i = 1; ex_rd_i = 6; pc_i = 32'h304;
        @(negedge clk);
        check("lu issue valid_o", valid_o, 1);
        check("lu issue rd_o", rd_o, 4);
        check("lu other rd stall_o", stall_o, 0);
        tick();
        ex_valid_i = 0; ex_load_i = 0;
        pc_i = 32'h200; instr_i = 32'hE28F0000;
        @(negedge clk);
        check("no-hz valid_o", valid_o, 1);

        // PC as Rn
        tick();
        pc_i = 32'h400; instr_i = 32'hE28214FF;
        @(negedge clk);
        check("pc rn_data_o", rn_data_o, 32'h208);

        // stall holds, flush beats stall
        tick();
        stall_i = 1; pc_i = 32'h500; instr_i = 32'hE0834005;
        @(negedge clk);
        check("stall1 pc_o", pc_o, 32'h400);
        tick();
        pc_i = 32'h504; instr_i = 32'hEAFFFFFE;
        @(negedge clk);
        check("stall2 pc_o", pc_o, 32'h400);
        tick();
        @(negedge clk);
        check("stall3 pc_o", pc_o, 32'h400);
        check("stall3 op2_o", op2_o, 32'hFF000000);
        tick();
        flush_i = 1;
        @(negedge clk);
        check("pre-flush valid_o", valid_o, 1);
        tick();
        flush_i = 0; stall_i = 0;
        @(negedge clk);
        check("flush valid_o", valid_o, 0);

        // flush alongside a hazard
        tick();
        flush_i = 1; instr_i = 32'hE0834005; ex_valid_i = 1; ex_load_i = 1; ex_rd_i = 5;
        @(negedge clk);
        check("flush+hz stall_o", stall_o, 1);
        tick();
        flush_i = 0; ex_valid_i = 0; instr_i = 32'hE0834015;
        @(negedge clk);
        check("flush+hz valid_o", valid_o, 0);

        // register-specified shift is undefined; invalid slot never flags it
        tick();
        valid_i = 0;
        @(negedge clk);
        check("undef undef_o", undef_o, 1);
        check("undef class_o", class_o, 0);
        tick();
        @(negedge clk);
        check("invalid undef_o", undef_o, 0);
        check("invalid valid_o", valid_o, 0);

        for (int n = 0; n < 3000; n++) begin
            tick();
            rst        = ($urandom_range(0, 99) == 0);
            valid_i    = ($urandom_range(0, 9) != 0);
            pc_i       = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            instr_i    = rand_instr();
            stall_i    = ($urandom_range(0, 6) == 0);
            flush_i    = ($urandom_range(0, 9) == 0);
            ex_valid_i = $urandom_range(0, 1);
            ex_load_i  = $urandom_range(0, 1);
            ex_rd_i    = 4'($urandom_range(0, 4));
            if (n % 50 == 0) rf[$urandom_range(0, 14)] = $urandom;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
